param_shift_reg: RTL

- Parametrised universal shift register; the next generation of the team's 4-bit load/shift register.
- Adds configurable width and an explicit load strobe, so all-zero data is loadable.
- Adds logical, arithmetic, rotate and serial-fill modes, plus a multi-cycle "shift N times" sequencer with a busy/done handshake.
- Used as a datapath utility, e.g. serialisers and shift-and-add arithmetic units.

---
 rtl/param_shift_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/param_shift_reg.sv
// Parametrised universal shift register with a multi-cycle shift sequencer.
// Supports logical, arithmetic, rotate and serial-fill modes.
module param_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             serial_in,
    output logic [WIDTH-1:0] d_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] M_SLL = 3'b000;
    localparam logic [2:0] M_SRL = 3'b001;
    localparam logic [2:0] M_SRA = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;
    localparam logic [2:0] M_SL  = 3'b101;
    localparam logic [2:0] M_SR  = 3'b110;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       mode_q, mode_d;

    logic [WIDTH-1:0] sh_data;
    logic             sh_bit;

    // One 1-bit step of the latched operation; reserved mode holds everything.
    always_comb begin
        sh_data = data_q;
        sh_bit  = so_q;
        case (mode_q)
            M_SLL: begin
                sh_data = {data_q[WIDTH-2:0], 1'b0};
                sh_bit  = data_q[WIDTH-1];
            end
            M_SRL: begin
                sh_data = {1'b0, data_q[WIDTH-1:1]};
                sh_bit  = data_q[0];
            end
            M_SRA: begin
                sh_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                sh_bit  = data_q[0];
            end
            M_ROL: begin
                sh_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                sh_bit  = data_q[WIDTH-1];
            end
            M_ROR: begin
                sh_data = {data_q[0], data_q[WIDTH-1:1]};
                sh_bit  = data_q[0];
            end
            M_SL: begin
                sh_data = {data_q[WIDTH-2:0], serial_in};
                sh_bit  = data_q[WIDTH-1];
            end
            M_SR: begin
                sh_data = {serial_in, data_q[WIDTH-1:1]};
                sh_bit  = data_q[0];
            end
            default: begin
                sh_data = data_q;
                sh_bit  = so_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        so_d    = so_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                priority case (1'b1)
                    load: data_d = d_in;
                    start && (count == '0): done_d = 1'b1;
                    start: begin
                        mode_d  = mode;
                        rem_d   = count;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                    default: ;
                endcase
            end
            SHIFT: begin
                data_d = sh_data;
                so_d   = sh_bit;
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign d_out      = data_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
